// File: rtl/dbus_pkg.sv
// Shared DBus definitions: default widths, arbiter state encoding and master indices.
package dbus_pkg;

    localparam int unsigned DBUS_ADDR_W = 30;
    localparam int unsigned DBUS_DATA_W = 32;
    localparam int unsigned DBUS_BE_W   = DBUS_DATA_W / 8;

    // Fixed master slots on the shared data bus
    localparam int unsigned CPU0 = 0;
    localparam int unsigned DMA0 = 1;
    localparam int unsigned VID0 = 2;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StGranted = 1'b1
    } arb_state_e;

    // Pointer width for a given master count (at least one bit)
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// Combinational round-robin selector: scans req starting one past ptr and
// returns a one-hot vector for the first requester found (zero if none).
module rr_pick #(
    parameter int unsigned NUM   = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NUM-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM-1:0]   gnt
);

    logic             found;
    int unsigned      idx;
    logic [PTR_W-1:0] sel;

    // Priority scan ptr+1, ptr+2, ..., ptr (mod NUM); the owner itself comes last
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int unsigned k = 1; k <= NUM; k++) begin
            idx = (32'(ptr) + k) % NUM;
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one DBus slave fabric among NUM_MASTERS masters.
// Registered one-hot grant; slave-side request mux and master-side response
// routing are combinational from the registered grant.
// Optional macro DBUS_ARB_LOCK_EN adds i_M_Lock: a locked, requesting owner keeps
// the bus across transactions for atomic read-modify-write sequences.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = DBUS_ADDR_W,
    parameter int unsigned DATA_W      = DBUS_DATA_W
) (
    input  logic                            i_Clk,
    input  logic                            i_nRst,
    input  logic [NUM_MASTERS-1:0]          i_M_Req,
`ifdef DBUS_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]          i_M_Lock,
`endif
    output logic [NUM_MASTERS-1:0]          o_M_Gnt,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   i_M_Address,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] i_M_ByteEn,
    input  logic [NUM_MASTERS-1:0]          i_M_Read,
    input  logic [NUM_MASTERS-1:0]          i_M_Write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   i_M_WriteData,
    output logic [NUM_MASTERS*DATA_W-1:0]   o_M_ReadData,
    output logic [NUM_MASTERS-1:0]          o_M_WaitRequest,
    output logic [ADDR_W-1:0]               o_S_Address,
    output logic [DATA_W/8-1:0]             o_S_ByteEn,
    output logic                            o_S_Read,
    output logic                            o_S_Write,
    output logic [DATA_W-1:0]               o_S_WriteData,
    input  logic [DATA_W-1:0]               i_S_ReadData,
    input  logic                            i_S_WaitRequest
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = ptr_width(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner;
    logic [PTR_W-1:0]       pick_ptr;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   lock_hold;

    // Index of the current owner (grant is one-hot or zero)
    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_q[i]) begin
                owner = PTR_W'(i);
            end
        end
    end

    // In GRANTED the scan starts after the owner, matching the pointer update
    assign pick_ptr = (state_q == StGranted) ? owner : ptr_q;

    rr_pick #(
        .NUM   (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (i_M_Req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

`ifdef DBUS_ARB_LOCK_EN
    // Only the owner's lock counts, and only while it still requests
    assign lock_hold = |(gnt_q & i_M_Lock & i_M_Req);
`else
    assign lock_hold = 1'b0;
`endif

    // Next-state: arbitrate from IDLE, or at the end of each unstalled transfer
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|i_M_Req) begin
                    gnt_d   = pick_gnt;
                    state_d = StGranted;
                end
            end
            StGranted: begin
                // A stalled slave pins grant and pointer so the owner's request stays put
                if (!i_S_WaitRequest) begin
                    ptr_d = owner;
                    if (lock_hold) begin
                        gnt_d = gnt_q;
                    end else if (|i_M_Req) begin
                        gnt_d = pick_gnt;
                    end else begin
                        gnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State, grant and pointer registers; pointer resets so master 0 wins first
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= PTR_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_M_Gnt = gnt_q;

    // Slave-side mux: AND-OR of the one-hot grant, so no grant drives all zeros
    always_comb begin
        o_S_Address   = '0;
        o_S_ByteEn    = '0;
        o_S_Read      = 1'b0;
        o_S_Write     = 1'b0;
        o_S_WriteData = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_q[i]) begin
                o_S_Address   = o_S_Address   | i_M_Address[i*ADDR_W +: ADDR_W];
                o_S_ByteEn    = o_S_ByteEn    | i_M_ByteEn[i*BE_W +: BE_W];
                o_S_Read      = o_S_Read      | i_M_Read[i];
                o_S_Write     = o_S_Write     | i_M_Write[i];
                o_S_WriteData = o_S_WriteData | i_M_WriteData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Master-side response: owner sees the slave; a strobing non-owner is stalled
    always_comb begin
        o_M_ReadData    = '0;
        o_M_WaitRequest = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_q[i]) begin
                o_M_ReadData[i*DATA_W +: DATA_W] = i_S_ReadData;
                o_M_WaitRequest[i]               = i_S_WaitRequest;
            end else begin
                o_M_WaitRequest[i] = i_M_Req[i] & (i_M_Read[i] | i_M_Write[i]);
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter with two masters.
// With DBUS_ARB_LOCK_EN defined, the lock sequence is exercised as well.
module tb_dbus_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic              clk;
    logic              nrst;
    logic [N-1:0]      req;
    logic [N-1:0]      lock;
    logic [N-1:0]      gnt;
    logic [N*AW-1:0]   addr;
    logic [N*DW/8-1:0] be;
    logic [N-1:0]      rd;
    logic [N-1:0]      wr;
    logic [N*DW-1:0]   wdata;
    logic [N*DW-1:0]   rdata;
    logic [N-1:0]      mwait;
    logic [AW-1:0]     s_addr;
    logic [DW/8-1:0]   s_be;
    logic              s_rd;
    logic              s_wr;
    logic [DW-1:0]     s_wdata;
    logic [DW-1:0]     s_rdata;
    logic              s_wait;

    int total = 0;
    int bad   = 0;

    dbus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .i_Clk           (clk),
        .i_nRst          (nrst),
        .i_M_Req         (req),
`ifdef DBUS_ARB_LOCK_EN
        .i_M_Lock        (lock),
`endif
        .o_M_Gnt         (gnt),
        .i_M_Address     (addr),
        .i_M_ByteEn      (be),
        .i_M_Read        (rd),
        .i_M_Write       (wr),
        .i_M_WriteData   (wdata),
        .o_M_ReadData    (rdata),
        .o_M_WaitRequest (mwait),
        .o_S_Address     (s_addr),
        .o_S_ByteEn      (s_be),
        .o_S_Read        (s_rd),
        .o_S_Write       (s_wr),
        .o_S_WriteData   (s_wdata),
        .i_S_ReadData    (s_rdata),
        .i_S_WaitRequest (s_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst    = 1'b0;
        req     = '0;
        lock    = '0;
        addr    = '0;
        be      = '0;
        rd      = '0;
        wr      = '0;
        wdata   = '0;
        s_rdata = '0;
        s_wait  = 1'b0;

        // Reset state
        #12;
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_s_rd", 64'(s_rd), 64'h0);
        check("rst_mwait", 64'(mwait), 64'h0);
        check("rst_rdata", 64'(rdata), 64'h0);
        nrst = 1'b1;

        // Idle after release: nothing granted, bus clean
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_gnt", 64'(gnt), 64'h0);
            check("idle_s_rd", 64'(s_rd), 64'h0);
            check("idle_s_wr", 64'(s_wr), 64'h0);
            check("idle_s_addr", 64'(s_addr), 64'h0);
        end

        // M0 single read; stalled until granted
        req[0]        = 1'b1;
        rd[0]         = 1'b1;
        addr[0+:AW]   = 30'h0640_1000;
        be[0+:4]      = 4'hF;
        addr[AW+:AW]  = 30'h0000_02A0;
        be[4+:4]      = 4'h3;
        #1;
        check("m0_pre_gnt", 64'(gnt), 64'h0);
        check("m0_pre_wait", 64'(mwait), 64'h1);
        tick();
        check("m0_gnt", 64'(gnt), 64'h1);
        check("m0_s_addr", 64'(s_addr), 64'h0640_1000);
        check("m0_s_rd", 64'(s_rd), 64'h1);
        check("m0_s_be", 64'(s_be), 64'hF);
        s_rdata = 32'hDEAD_BEEF;
        #1;
        check("m0_rdata0", 64'(rdata[0+:DW]), 64'hDEAD_BEEF);
        check("m0_rdata1", 64'(rdata[DW+:DW]), 64'h0);
        check("m0_mwait", 64'(mwait), 64'h0);
        req = '0;
        rd  = '0;
        tick();
        check("m0_release", 64'(gnt), 64'h0);

        // Both masters read continuously; last owner was M0 so M1 comes first
        req = 2'b11;
        rd  = 2'b11;
        tick();
        check("rr_g1", 64'(gnt), 64'h2);
        check("rr_w1", 64'(mwait), 64'h1);
        check("rr_a1", 64'(s_addr), 64'h2A0);
        tick();
        check("rr_g2", 64'(gnt), 64'h1);
        check("rr_w2", 64'(mwait), 64'h2);
        tick();
        check("rr_g3", 64'(gnt), 64'h2);
        tick();
        check("rr_g4", 64'(gnt), 64'h1);

        // M1 takes the bus and writes; slave stalls three cycles
        rd[1]         = 1'b0;
        wr[1]         = 1'b1;
        wdata[DW+:DW] = 32'h1234_5678;
        tick();
        check("st_gnt0", 64'(gnt), 64'h2);
        s_wait = 1'b1;
        #1;
        check("st_s_wr", 64'(s_wr), 64'h1);
        check("st_s_rd", 64'(s_rd), 64'h0);
        check("st_s_wdata", 64'(s_wdata), 64'h1234_5678);
        check("st_s_be", 64'(s_be), 64'h3);
        check("st_mwait", 64'(mwait), 64'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold", 64'(gnt), 64'h2);
        end
        s_wait = 1'b0;
        tick();
        check("st_switch", 64'(gnt), 64'h1);

        // Asynchronous reset while M1 owns with wait high
        tick();
        check("ar_pre", 64'(gnt), 64'h2);
        s_wait = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        check("ar_gnt", 64'(gnt), 64'h0);
        check("ar_s_wr", 64'(s_wr), 64'h0);
        check("ar_s_addr", 64'(s_addr), 64'h0);
        #1;
        nrst   = 1'b1;
        s_wait = 1'b0;
        tick();
        check("ar_first", 64'(gnt), 64'h1);
        req = '0;
        rd  = '0;
        wr  = '0;
        tick();
        check("ar_idle", 64'(gnt), 64'h0);

`ifdef DBUS_ARB_LOCK_EN
        // Fresh reset so M0 wins first, then M0 locks across four transfers
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        req  = 2'b11;
        rd   = 2'b11;
        lock = 2'b01;
        tick();
        check("lk_first", 64'(gnt), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lk_hold", 64'(gnt), 64'h1);
        end
        lock = '0;
        tick();
        check("lk_release", 64'(gnt), 64'h2);
        req = '0;
        rd  = '0;
        tick();
        check("lk_idle", 64'(gnt), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single shared DBus slave fabric (address decode, OR-combined ReadData/WaitRequest) between up to four DBus masters: CPU0, plus the planned DMA and video-fetch masters.
- Replaces the single-master grant register that sits in the SOC top level today.
- Round-robin arbitration with a registered one-hot grant.
- Muxes the granted master's request onto the slave-side bus and routes the response back.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- ADDR_W, 30, word address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- i_Clk  in  1  system clock (75 MHz SysClk domain).
- i_nRst  in  1  asynchronous active-low reset.
- i_M_Req  in  NUM_MASTERS  per-master bus request (CPU o_DBus_Req_E style).
- o_M_Gnt  out  NUM_MASTERS  registered one-hot grant.
- i_M_Address  in  NUM_MASTERS*ADDR_W  flattened master addresses; master i occupies slice i.
- i_M_ByteEn  in  NUM_MASTERS*DATA_W/8  flattened byte enables.
- i_M_Read  in  NUM_MASTERS  read strobes.
- i_M_Write  in  NUM_MASTERS  write strobes.
- i_M_WriteData  in  NUM_MASTERS*DATA_W  flattened write data.
- o_M_ReadData  out  NUM_MASTERS*DATA_W  per-master read data.
- o_M_WaitRequest  out  NUM_MASTERS  per-master stall.
- o_S_Address  out  ADDR_W  to slave decode.
- o_S_ByteEn  out  DATA_W/8  to slaves.
- o_S_Read  out  1  to slaves.
- o_S_Write  out  1  to slaves.
- o_S_WriteData  out  DATA_W  to slaves.
- i_S_ReadData  in  DATA_W  OR-combined slave read data.
- i_S_WaitRequest  in  1  OR-combined slave wait request.

Behaviour:
- Clock/reset (already decided): one clock i_Clk; reset i_nRst is asynchronous, active-low.
- Reset values:
  - o_M_Gnt = 0.
  - Round-robin pointer = NUM_MASTERS-1, so master 0 wins first.
  - State = IDLE.
  - All o_S_* = 0.
  - o_M_WaitRequest = 0; o_M_ReadData = 0.
- Reset asserted mid-transaction clears the grant immediately; no slave strobe survives reset.
- State machine:
  - IDLE: no grant.
    - If any i_M_Req, register a one-hot grant to the first requester found scanning from pointer+1 (modulo NUM_MASTERS), then go to GRANTED.
  - GRANTED: evaluated each cycle.
    - i_S_WaitRequest=1: hold grant and pointer unchanged.
    - i_S_WaitRequest=0: pointer <= current owner; re-arbitrate among current i_M_Req using the same scan. Others requesting → rotate away from the owner. Only the owner requesting → owner keeps the grant. Nobody requesting → grant 0 and go to IDLE.
- Latency: request seen at edge n → o_M_Gnt valid after edge n (cycle n+1). No combinational path from i_M_Req to o_M_Gnt.
- Slave-side mux: combinational from the registered grant.
  - o_S_* carry the granted master's fields.
  - With no grant, o_S_Read = 0, o_S_Write = 0, and all other o_S_* = 0 (OR-bus clean).
- Master-side response:
  - o_M_ReadData slice i = i_S_ReadData when Gnt[i], else 0.
  - o_M_WaitRequest[i] = Gnt[i] ? i_S_WaitRequest : (i_M_Req[i] & (i_M_Read[i] | i_M_Write[i])). A master strobing without a grant is stalled.
- Grant is never changed while i_S_WaitRequest=1; the owner's Address/strobes must stay stable (slave contract).
- Simultaneous requests by all masters: strict rotation 0,1,..,N-1,0; no master waits more than N-1 transactions.
- Grant is always one-hot or zero.

Optional Feature:
- Macro: DBUS_ARB_LOCK_EN.
- Defined: adds input i_M_Lock [NUM_MASTERS]. While the owner holds both i_M_Lock and i_M_Req, re-arbitration is suppressed and the owner keeps the grant regardless of other requests, for atomic read-modify-write. Lock is ignored from non-owners, and lock without req releases normally.
- Undefined: the port is absent and behaviour is pure round-robin as above.

Decomposition:
- Shared package dbus_pkg:
  - ADDR_W and DATA_W defaults.
  - Byte-enable width constant.
  - IDLE/GRANTED state encoding.
  - Master index constants (CPU0=0, DMA0=1, VID0=2).
- One natural sub-module, rr_pick: combinational round-robin selector (req vector + pointer → one-hot).

Test Plan:
- Reset release, no requests → o_M_Gnt=0, o_S_Read=0, o_S_Write=0, o_S_Address=0 on every cycle.
- M0 reads addr 0x0640_1000 alone → Gnt=0b01 one cycle after Req; o_S_Address=0x0640_1000; o_M_ReadData[0] = slave data 0xDEADBEEF; o_M_ReadData[1]=0.
- M0 and M1 both request continuously, slave wait=0 → grant sequence 01,10,01,10; the non-owner's o_M_WaitRequest=1 while it strobes.
- M1 owns, slave holds WaitRequest high 3 cycles while M0 requests → Gnt stays 0b10 for those 3 cycles; switches to 0b01 the cycle after WaitRequest drops.
- i_nRst asserted while M1 granted with wait high → Gnt=0 and o_S_Write=0 immediately (asynchronous); after release, master 0 wins first.
- DBUS_ARB_LOCK_EN defined: M0 holds Lock+Req for 4 transactions while M1 requests → Gnt=0b01 throughout; M1 granted the cycle after M0 drops Lock.
